// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers on the core's
// word-addressed MMIO bus, a small TX FIFO and a serializer driving o_tx.
module mmio_uart_tx #(
  parameter logic [29:0] BASE_ADDR   = 30'h0000_0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_mmio_addr,
  input  logic [31:0] i_mmio_data,
  input  logic [3:0]  i_mmio_mask,
  input  logic        i_mmio_wren,
  output logic [31:0] o_mmio_data,
  output logic        o_mmio_sel,
  output logic        o_tx
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;

  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_bdiv;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic [1:0]    w_off;
  logic          w_wr, w_push, w_push_ok, w_pop;
  logic          w_empty, w_full, w_bit_end, w_busy, w_tx;
  logic [15:0]   w_div_eff;
  logic [31:0]   w_status, w_rdata;
  logic          w_unused;

  assign o_mmio_sel = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
  assign w_off      = i_mmio_addr[1:0];
  assign w_wr       = o_mmio_sel && i_mmio_wren;
  assign w_push     = w_wr && (w_off == 2'd0) && i_mmio_mask[0];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_bit_end  = (r_cnt == r_bdiv - 16'd1);
  assign w_busy     = (r_state != S_IDLE);
  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;

  // Pops only look at the registered count, so a byte is never popped in the
  // same cycle it is pushed.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                                   (r_state == S_STOP && w_bit_end));
  assign w_push_ok  = w_push && (!w_full || w_pop);

  assign w_unused   = ^{i_mmio_data[31:17], i_mmio_mask[3]};

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_mmio_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow is sticky; a dropped push in the same cycle as a W1C keeps it set.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop)
      r_ovf <= 1'b1;
    else if (w_wr && (w_off == 2'd1) && i_mmio_mask[2] && i_mmio_data[16])
      r_ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DEFAULT_DIV;
    end else if (w_wr && (w_off == 2'd2)) begin
      if (i_mmio_mask[0]) r_div[7:0]  <= i_mmio_data[7:0];
      if (i_mmio_mask[1]) r_div[15:8] <= i_mmio_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bdiv  <= 16'd1;
      r_bidx  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift <= r_mem[r_rptr];
            r_bdiv  <= w_div_eff;
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bidx == 3'd7) r_state <= S_STOP;
            else                r_bidx  <= r_bidx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_shift <= r_mem[r_rptr];
              r_bdiv  <= w_div_eff;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Line level follows the state one cycle later through r_tx.
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shift[0];
      default: w_tx = 1'b1;
    endcase
  end

  assign w_status = {15'b0, r_ovf, 5'b0, w_busy, w_empty, w_full, 8'(r_count)};

  always_comb begin
    w_rdata = '0;
    if (o_mmio_sel) begin
      case (w_off)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'b0, r_div};
        default: w_rdata = '0;
      endcase
    end
  end

  assign o_mmio_data = w_rdata;
  assign o_tx        = r_tx;
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is the responder on the CPU core's MMIO bus: word address, 32-bit write data, byte mask, write enable, and read data returned to the core.
- CPU stores to the DATA register push bytes into a small TX FIFO. A serializer drains the FIFO as 8N1 frames on o_tx.
- Read data is combinational, so the single-cycle core gets the value in the same cycle. Output is zero when not selected, so several responders can be OR-merged.

Parameters:
- BASE_ADDR, 30'h0000_0100, word address of register 0; bits [1:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16, reset value of the DIV register (clocks per bit).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_mmio_addr  in  30  word address from the core.
- i_mmio_data  in  32  write data from the core.
- i_mmio_mask  in  4  byte-lane enables for the write.
- i_mmio_wren  in  1  write strobe, one cycle per store.
- o_mmio_data  out  32  read data, combinational; 0 when not selected.
- o_mmio_sel  out  1  combinational; high when i_mmio_addr[29:2] == BASE_ADDR[29:2].
- o_tx  out  1  serial output, registered; idle high.

Behaviour:
- Decode:
  - off = i_mmio_addr[1:0]. Writes act only when o_mmio_sel && i_mmio_wren.
  - off 0 = DATA, off 1 = STATUS, off 2 = DIV, off 3 = reserved (reads 0, writes ignored).
- DATA:
  - A write with mask[0]=1 pushes i_mmio_data[7:0]. Writes with mask[0]=0 are ignored.
  - Reads return 0.
- STATUS (read):
  - [7:0] FIFO count, [8] full, [9] empty, [10] busy (state != IDLE), [16] overflow; all other bits 0.
  - A write with mask[2]=1 and data[16]=1 clears overflow (W1C). All other bits are read-only.
- DIV:
  - Bits [15:0] hold the divisor; byte lanes 0 and 1 are writable per mask. Reads return {16'b0, DIV}.
  - An effective divisor of 0 is treated as 1.
  - The divisor is latched at frame start; a write mid-frame affects the next frame only.
- FIFO:
  - Push when full with no pop in the same cycle: the byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle when full: both happen and count is unchanged.
  - Overflow set and W1C clear in the same cycle: set wins.
  - No bypass: a byte pushed at edge N is poppable at edge N+1 at the earliest.
- Serializer FSM: IDLE, START, DATA, STOP. A bit counter runs from 0 to div-1 and a bit index runs 0..7.
  - IDLE: o_tx=1. If the FIFO is not empty: pop, load the shift register, latch the divisor, go to START. o_tx drives 0 from the next edge.
  - START: hold o_tx=0 for div cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held div cycles, then go to STOP.
  - STOP: o_tx=1 for div cycles. At the end, if the FIFO is not empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
  - Frame length is exactly 10*div cycles.
  - Latency: for a push at edge N into an empty FIFO with the FSM idle, o_tx falls after edge N+2.
- Reset (rst=1 at an edge), including mid-frame:
  - FIFO emptied, overflow=0, DIV=DEFAULT_DIV, state=IDLE, o_tx=1.
  - The in-flight frame is abandoned with no completion.
  - o_mmio_data and o_mmio_sel stay purely combinational from the address.

Test Plan:
- Reset, then read offsets 0..3 -> 0, 0x00000200 (empty), 0x00000010, 0; o_tx=1 throughout.
- Write DIV=4 (mask 0011), write DATA=0x55 (mask 0001) -> o_tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. Total 40 cycles. busy=1 during the frame, 0 after.
- Write DATA with mask 0010 (data 0xAB00) -> no push; count stays 0; o_tx stays 1.
- With DIV=4, push 0x01..0x06 back-to-back (6 stores while the first frame starts):
  - 5 bytes accepted (1 popped + 4 queued); overflow=1.
  - Frames for 0x01..0x05 are emitted with no idle gap between them.
  - Write STATUS 0x00010000 with mask 0100 -> overflow=0.
- Write DIV=0, then push 0xFF -> frame lasts 10 cycles (div treated as 1). Write DIV=8 mid-frame -> current frame unaffected; the next frame is 80 cycles.
- Assert rst during the DATA bits of a frame with 2 bytes queued -> o_tx=1 next cycle, count=0, no further frames, DIV back to 16.
- Access address BASE_ADDR+4 -> o_mmio_sel=0, o_mmio_data=0, a write there has no effect.
